// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants and response-owner encoding for the memory arbiter
package mem_arbiter_pkg;

  localparam int CORE_DATAWIDTH = 32;
  localparam int BE_WIDTH       = 4;
  localparam int STARVE_CW      = 4;

  localparam logic [BE_WIDTH-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_DM = 2'd2
  } resp_state_t;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// rtl/mem_arbiter_arb_prio.sv - DM-priority grant logic with IF anti-starvation counter
module arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  output logic if_gnt,
  output logic dm_gnt
);

  localparam logic [STARVE_CW-1:0] LIMIT = STARVE_CW'(STARVE_LIMIT);

  logic [STARVE_CW-1:0] starve_cnt;
  logic                 starved;

  assign starved = (starve_cnt == LIMIT);

  // Grants: DM wins a tie unless IF has already been passed over LIMIT times; nothing granted in reset
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      if_gnt = if_req && (!dm_req || starved);
      dm_gnt = dm_req && !if_gnt;
    end
  end

  // Count consecutive DM wins while IF is waiting; cleared once IF is served or withdraws
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (dm_gnt && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (IF/DM) arbiter in front of one single-port synchronous memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATAWIDTH    = CORE_DATAWIDTH,
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  MEM_ARBITER_Clk_in,
  input  logic                  MEM_ARBITER_Reset_in,
  input  logic                  IF_Req_in,
  input  logic [ADDR_WIDTH-1:0] IF_Addr_InBUS,
  output logic                  IF_Gnt_out,
  output logic                  IF_Rvalid_out,
  output logic [DATAWIDTH-1:0]  IF_Rdata_OutBUS,
  input  logic                  DM_Req_in,
  input  logic                  DM_We_in,
  input  logic [BE_WIDTH-1:0]   DM_Byteenable_InBUS,
  input  logic [ADDR_WIDTH-1:0] DM_Addr_InBUS,
  input  logic [DATAWIDTH-1:0]  DM_Wdata_InBUS,
  output logic                  DM_Gnt_out,
  output logic                  DM_Rvalid_out,
  output logic [DATAWIDTH-1:0]  DM_Rdata_OutBUS,
  output logic                  MEM_Re_out,
  output logic                  MEM_We_out,
  output logic [BE_WIDTH-1:0]   MEM_Byteenable_OutBUS,
  output logic [ADDR_WIDTH-1:0] MEM_Addr_OutBUS,
  output logic [DATAWIDTH-1:0]  MEM_Wdata_OutBUS,
  input  logic [DATAWIDTH-1:0]  MEM_Rdata_InBUS
);

  logic        if_gnt;
  logic        dm_gnt;
  resp_state_t state;

  arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb_prio (
    .clk    (MEM_ARBITER_Clk_in),
    .rst    (MEM_ARBITER_Reset_in),
    .if_req (IF_Req_in),
    .dm_req (DM_Req_in),
    .if_gnt (if_gnt),
    .dm_gnt (dm_gnt)
  );

  assign IF_Gnt_out = if_gnt;
  assign DM_Gnt_out = dm_gnt;

  // Steer the granted port onto the memory side; idle cycles drive an all-zero bus
  always_comb begin
    MEM_Re_out            = 1'b0;
    MEM_We_out            = 1'b0;
    MEM_Byteenable_OutBUS = '0;
    MEM_Addr_OutBUS       = '0;
    MEM_Wdata_OutBUS      = '0;
    if (if_gnt) begin
      MEM_Re_out            = 1'b1;
      MEM_Byteenable_OutBUS = BE_ALL;
      MEM_Addr_OutBUS       = IF_Addr_InBUS;
    end else if (dm_gnt) begin
      MEM_Addr_OutBUS = DM_Addr_InBUS;
      if (DM_We_in) begin
        MEM_We_out            = 1'b1;
        MEM_Byteenable_OutBUS = DM_Byteenable_InBUS;
        MEM_Wdata_OutBUS      = DM_Wdata_InBUS;
      end else begin
        MEM_Re_out            = 1'b1;
        MEM_Byteenable_OutBUS = BE_ALL;
      end
    end
  end

  // Remember which port owns the read data returning next cycle; reset drops any pending response
  always_ff @(posedge MEM_ARBITER_Clk_in or posedge MEM_ARBITER_Reset_in) begin
    if (MEM_ARBITER_Reset_in) begin
      state <= IDLE;
    end else if (if_gnt) begin
      state <= RESP_IF;
    end else if (dm_gnt && !DM_We_in) begin
      state <= RESP_DM;
    end else begin
      state <= IDLE;
    end
  end

  assign IF_Rvalid_out   = (state == RESP_IF);
  assign DM_Rvalid_out   = (state == RESP_DM);
  assign IF_Rdata_OutBUS = (state == RESP_IF) ? MEM_Rdata_InBUS : '0;
  assign DM_Rdata_OutBUS = (state == RESP_DM) ? MEM_Rdata_InBUS : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 32: data bus width.
REQ-002 Parameter ADDR_WIDTH, default 10: memory word-address width.
REQ-003 Parameter STARVE_LIMIT, default 4: maximum consecutive DM grants allowed while IF waits; legal range 1 to 15.
REQ-004 MEM_ARBITER_Clk_in  in  1  sole clock; all state changes on the rising edge.
REQ-005 MEM_ARBITER_Reset_in  in  1  reset, asynchronous, active-high.
REQ-006 IF_Req_in  in  1  instruction-fetch read request.
REQ-007 IF_Addr_InBUS  in  ADDR_WIDTH  fetch address.
REQ-008 IF_Gnt_out  out  1  fetch request accepted this cycle.
REQ-009 IF_Rvalid_out  out  1  fetch read data valid.
REQ-010 IF_Rdata_OutBUS  out  DATAWIDTH  fetch read data.
REQ-011 DM_Req_in  in  1  data-port request.
REQ-012 DM_We_in  in  1  1 = write, 0 = read.
REQ-013 DM_Byteenable_InBUS  in  4  byte lanes for writes.
REQ-014 DM_Addr_InBUS  in  ADDR_WIDTH  data address.
REQ-015 DM_Wdata_InBUS  in  DATAWIDTH  write data.
REQ-016 DM_Gnt_out, DM_Rvalid_out  out  1 each  data-port grant and read-valid.
REQ-017 DM_Rdata_OutBUS  out  DATAWIDTH  data-port read data.
REQ-018 MEM_Re_out, MEM_We_out  out  1 each  memory read and write strobes.
REQ-019 MEM_Byteenable_OutBUS  out  4; MEM_Addr_OutBUS  out  ADDR_WIDTH; MEM_Wdata_OutBUS  out  DATAWIDTH.
REQ-020 MEM_Rdata_InBUS  in  DATAWIDTH  memory read data, valid one cycle after MEM_Re_out.

Function
REQ-021 The block SHALL share one single-port synchronous memory between the IF and DM requesters, accepting at most one access per cycle.
REQ-022 Gnt SHALL be combinational from the Req inputs and the registered starvation state; a port's request is accepted in any cycle where its Req and Gnt are both 1.
REQ-023 Arbitration: only one Req high -> that port granted; both high -> DM granted unless starve_cnt == STARVE_LIMIT, in which case IF is granted.
REQ-024 starve_cnt SHALL increment on a DM grant while IF_Req_in is 1, clear on an IF grant or when IF_Req_in is 0, and saturate at STARVE_LIMIT.
REQ-025 In the grant cycle, MEM_* outputs SHALL carry the granted port's address, strobes and, for DM writes, Wdata and Byteenable; IF grants drive MEM_We_out = 0 and MEM_Byteenable_OutBUS = 4'hF.
REQ-026 With no grant, MEM_Re_out and MEM_We_out SHALL be 0.
REQ-027 A read granted in cycle N SHALL assert exactly one Rvalid pulse for the owning port in cycle N+1, with Rdata equal to MEM_Rdata_InBUS; DM writes produce no Rvalid.
REQ-028 Response owner FSM: states IDLE, RESP_IF, RESP_DM. The next state SHALL be RESP_IF after an IF read grant, RESP_DM after a DM read grant, and IDLE otherwise.
REQ-029 Back-to-back grants SHALL be supported: a new grant may occur in the same cycle as the previous response, giving a throughput of 1 access per cycle.
REQ-030 A non-owning port's Rdata SHALL be 0.

Reset
REQ-031 While reset is asserted, the FSM SHALL be IDLE, starve_cnt 0, all Gnt, Rvalid, MEM_Re_out and MEM_We_out 0, and all data buses 0.
REQ-032 Reset asserted mid-access SHALL discard any pending response, so no Rvalid is produced after release.
REQ-033 The first grant after release SHALL occur no earlier than the first rising edge at which reset is low.

Structure
REQ-034 The FSM state encoding and the DATAWIDTH and byte-enable-width constants SHALL reside in the shared core package.
REQ-035 The starvation counter and the priority logic SHALL form one sub-module, arb_prio.
REQ-036 The mem_arbiter module SHALL contain the FSM, the MEM_* multiplexing and the response routing.

Verification
REQ-037 IF-only reads at addresses 0, 1 and 2 on consecutive cycles -> IF_Gnt_out 1 for 3 cycles; IF_Rvalid_out 1 for 3 cycles starting one cycle later; Rdata equals the memory words.
REQ-038 DM write of 0xDEADBEEF to address 5 with byteenable 4'b0011, then DM read of address 5 -> DM_Rvalid_out one cycle after the read grant, with data 0x0000BEEF over a zero-initialised memory.
REQ-039 Both ports requesting continuously with STARVE_LIMIT = 4 -> grant pattern DM, DM, DM, DM, IF, repeating; no IF_Rvalid_out/DM_Rvalid_out cross-routing.
REQ-040 Simultaneous IF and DM read in one cycle -> only DM_Gnt_out is 1; IF_Gnt_out is 0 and the IF request is held until granted in a later cycle.
REQ-041 Reset asserted in the cycle after a DM read grant -> DM_Rvalid_out stays 0; after release all outputs are 0 until a new Req arrives.
